// File: rtl/alu_pkg.sv
// Shared definitions for the ALU sequencer: opcode map, instruction word layout
// and sequencer FSM encoding.
package alu_pkg;

    localparam logic [3:0] OP_ADD  = 4'h0;
    localparam logic [3:0] OP_SUB  = 4'h1;
    localparam logic [3:0] OP_MUL  = 4'h2;
    localparam logic [3:0] OP_AND  = 4'h3;
    localparam logic [3:0] OP_OR   = 4'h4;
    localparam logic [3:0] OP_XOR  = 4'h5;
    localparam logic [3:0] OP_NAND = 4'h6;
    localparam logic [3:0] OP_NOR  = 4'h7;
    localparam logic [3:0] OP_SHL  = 4'h8;
    localparam logic [3:0] OP_SHR  = 4'h9;
    localparam logic [3:0] OP_ADDA = 4'hA;
    localparam logic [3:0] OP_MULA = 4'hB;
    localparam logic [3:0] OP_MAC  = 4'hC;
    localparam logic [3:0] OP_EQU  = 4'hD;
    localparam logic [3:0] OP_LTH  = 4'hE;
    localparam logic [3:0] OP_HALT = 4'hF;

    localparam int INSTR_W = 20;

    // Program word as stored by the host: {opcode, A, B}
    typedef struct packed {
        logic [3:0] opcode;
        logic [7:0] a;
        logic [7:0] b;
    } instr_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT,
        ST_DONE
    } seq_state_t;

endpackage

// File: rtl/alu_sequencer_if.sv
// Operand/result bus between the sequencer (master) and the ALU (slave).
interface alu_sequencer_if;
    logic [3:0] alu_opcode;
    logic [7:0] alu_a;
    logic [7:0] alu_b;
    logic [7:0] alu_result;

    modport master (output alu_opcode, output alu_a, output alu_b, input alu_result);
    modport slave  (input alu_opcode, input alu_a, input alu_b, output alu_result);
endinterface

// File: rtl/seq_ram.sv
// DEPTH x W RAM: one write port, one registered read port.
// WR_FIRST selects whether a same-address read returns the word being written.
module seq_ram #(
    parameter int DEPTH    = 16,
    parameter int AW       = 4,
    parameter int W        = 8,
    parameter bit WR_FIRST = 1'b0
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [W-1:0]  wdata,
    input  logic [AW-1:0] raddr,
    output logic [W-1:0]  rdata
);

    logic [W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        if (rst) begin
            rdata <= '0;
        end else if (WR_FIRST && we && (waddr == raddr)) begin
            rdata <= wdata;
        end else begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/alu_sequencer.sv
// Self-running operand feeder: replays a host-loaded program into the ALU and
// stores each ALU_Out in a result RAM the host can read back.
module alu_sequencer
    import alu_pkg::*;
#(
    parameter int DEPTH   = 16,
    parameter int AW      = 4,
    parameter int ALU_LAT = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 prog_we,
    input  logic [AW-1:0]        prog_addr,
    input  logic [INSTR_W-1:0]   prog_data,
    input  logic [AW:0]          prog_len,
    input  logic                 start,
    output logic                 busy,
    output logic                 done,
    output logic [AW:0]          res_count,
    input  logic [AW-1:0]        res_addr,
    output logic [7:0]           res_data,
    alu_sequencer_if.master      alu
);

    localparam int CW = (ALU_LAT > 1) ? $clog2(ALU_LAT) : 1;

    seq_state_t    state_reg;
    logic [AW-1:0] pc_reg;
    logic [AW:0]   len_reg;
    logic [CW-1:0] cnt_reg;
    logic          busy_reg;
    logic          done_reg;
    logic [AW:0]   res_count_reg;
    logic [3:0]    op_reg;
    logic [7:0]    a_reg;
    logic [7:0]    b_reg;

    instr_t        prog_word;
    logic          prog_wen;
    logic [AW-1:0] prog_raddr;
    logic          res_we;
    logic [AW:0]   len_clamped;
    logic [AW:0]   pc_next_ext;
    logic          idle_like;

    assign idle_like   = (state_reg == ST_IDLE) || (state_reg == ST_DONE);
    assign len_clamped = (prog_len > (AW+1)'(DEPTH)) ? (AW+1)'(DEPTH) : prog_len;
    assign pc_next_ext = {1'b0, pc_reg} + 1'b1;
    assign prog_wen    = prog_we && idle_like && !rst;
    assign res_we      = !rst && (state_reg == ST_WAIT) && (cnt_reg == '0);

    // Outside a run the read port parks on word 0 so the first instruction is
    // ready when start arrives; during a run it prefetches the next word.
    assign prog_raddr  = (rst || idle_like) ? '0 : pc_next_ext[AW-1:0];

    seq_ram #(
        .DEPTH    (DEPTH),
        .AW       (AW),
        .W        (INSTR_W),
        .WR_FIRST (1'b1)
    ) u_prog_ram (
        .clk   (clk),
        .rst   (1'b0),
        .we    (prog_wen),
        .waddr (prog_addr),
        .wdata (prog_data),
        .raddr (prog_raddr),
        .rdata (prog_word)
    );

    seq_ram #(
        .DEPTH    (DEPTH),
        .AW       (AW),
        .W        (8),
        .WR_FIRST (1'b0)
    ) u_res_ram (
        .clk   (clk),
        .rst   (rst),
        .we    (res_we),
        .waddr (pc_reg),
        .wdata (alu.alu_result),
        .raddr (res_addr),
        .rdata (res_data)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= ST_IDLE;
            pc_reg        <= '0;
            len_reg       <= '0;
            cnt_reg       <= '0;
            busy_reg      <= 1'b0;
            done_reg      <= 1'b0;
            res_count_reg <= '0;
            op_reg        <= '0;
            a_reg         <= '0;
            b_reg         <= '0;
        end else begin
            done_reg <= 1'b0;
            case (state_reg)
                ST_IDLE: begin
                    if (start) begin
                        pc_reg        <= '0;
                        res_count_reg <= '0;
                        // An empty program or a leading HALT ends the run without touching the ALU
                        if ((len_clamped == '0) || (prog_word.opcode == OP_HALT)) begin
                            done_reg  <= 1'b1;
                            state_reg <= ST_DONE;
                        end else begin
                            len_reg   <= len_clamped;
                            op_reg    <= prog_word.opcode;
                            a_reg     <= prog_word.a;
                            b_reg     <= prog_word.b;
                            busy_reg  <= 1'b1;
                            state_reg <= ST_ISSUE;
                        end
                    end
                end
                ST_ISSUE: begin
                    cnt_reg   <= CW'(ALU_LAT - 1);
                    state_reg <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (cnt_reg != '0) begin
                        cnt_reg <= cnt_reg - 1'b1;
                    end else begin
                        res_count_reg <= res_count_reg + 1'b1;
                        if ((pc_next_ext == len_reg) || (prog_word.opcode == OP_HALT)) begin
                            busy_reg  <= 1'b0;
                            done_reg  <= 1'b1;
                            state_reg <= ST_DONE;
                        end else begin
                            pc_reg    <= pc_reg + 1'b1;
                            op_reg    <= prog_word.opcode;
                            a_reg     <= prog_word.a;
                            b_reg     <= prog_word.b;
                            state_reg <= ST_ISSUE;
                        end
                    end
                end
                ST_DONE: begin
                    state_reg <= ST_IDLE;
                end
                default: begin
                    state_reg <= ST_IDLE;
                end
            endcase
        end
    end

    assign busy           = busy_reg;
    assign done           = done_reg;
    assign res_count      = res_count_reg;
    assign alu.alu_opcode = op_reg;
    assign alu.alu_a      = a_reg;
    assign alu.alu_b      = b_reg;

endmodule

// File: tb/tb_alu_sequencer.sv
// Bench for alu_sequencer: two instances (ALU latency 1 and 3) driven by a stand-in
// ALU, checked cycle by cycle against a program-level model of each run.
module tb_alu_sequencer;
    import alu_pkg::*;

    localparam int DEPTH = 16;
    localparam int AW    = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  prog_we;
    logic [1:0]  start;
    logic [3:0]  prog_addr;
    logic [19:0] prog_data;
    logic [4:0]  prog_len;
    logic [3:0]  res_addr;
    logic [1:0]  busy_v;
    logic [1:0]  done_v;
    logic [4:0]  res_count_w [2];
    logic [7:0]  res_data_w  [2];
    logic [19:0] alu_w       [2];

    alu_sequencer_if bus0 ();
    alu_sequencer_if bus1 ();

    always #5 clk = ~clk;

    alu_sequencer #(.DEPTH(DEPTH), .AW(AW), .ALU_LAT(1)) u_dut0 (
        .clk(clk), .rst(rst), .prog_we(prog_we[0]), .prog_addr(prog_addr),
        .prog_data(prog_data), .prog_len(prog_len), .start(start[0]),
        .busy(busy_v[0]), .done(done_v[0]), .res_count(res_count_w[0]),
        .res_addr(res_addr), .res_data(res_data_w[0]), .alu(bus0)
    );

    alu_sequencer #(.DEPTH(DEPTH), .AW(AW), .ALU_LAT(3)) u_dut1 (
        .clk(clk), .rst(rst), .prog_we(prog_we[1]), .prog_addr(prog_addr),
        .prog_data(prog_data), .prog_len(prog_len), .start(start[1]),
        .busy(busy_v[1]), .done(done_v[1]), .res_count(res_count_w[1]),
        .res_addr(res_addr), .res_data(res_data_w[1]), .alu(bus1)
    );

    assign alu_w[0] = {bus0.alu_opcode, bus0.alu_a, bus0.alu_b};
    assign alu_w[1] = {bus1.alu_opcode, bus1.alu_a, bus1.alu_b};

    // Stand-in ALU: a pure function of its operands, pipelined by the latency
    function automatic logic [7:0] alu_f(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
        logic [7:0] r;
        case (op)
            OP_ADD:  r = a + b;
            OP_SUB:  r = a - b;
            OP_MUL:  r = a * b;
            OP_AND:  r = a & b;
            OP_OR:   r = a | b;
            OP_XOR:  r = a ^ b;
            OP_NAND: r = ~(a & b);
            OP_NOR:  r = ~(a | b);
            OP_SHL:  r = a << 1;
            OP_SHR:  r = a >> 1;
            OP_ADDA: r = a + b + 8'd1;
            OP_MULA: r = a * b + 8'd3;
            OP_MAC:  r = a * b + a;
            OP_EQU:  r = {7'd0, a == b};
            OP_LTH:  r = {7'd0, a < b};
            default: r = 8'h00;
        endcase
        return r;
    endfunction

    logic [7:0] pipe1 [2];
    always @(posedge clk) begin
        bus0.alu_result <= alu_f(bus0.alu_opcode, bus0.alu_a, bus0.alu_b);
        pipe1[0]        <= alu_f(bus1.alu_opcode, bus1.alu_a, bus1.alu_b);
        pipe1[1]        <= pipe1[0];
        bus1.alu_result <= pipe1[1];
    end

    logic [19:0] prog_m [2][DEPTH];
    logic [7:0]  res_m  [2][DEPTH];
    bit          res_ok [2][DEPTH];
    logic [19:0] last_alu [2];

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic load(input int addr, input logic [19:0] w);
        prog_we   = 2'b11;
        prog_addr = 4'(addr);
        prog_data = w;
        @(negedge clk);
        prog_we = 2'b00;
        prog_m[0][addr] = w;
        prog_m[1][addr] = w;
    endtask

    task automatic rd(input int s, input int a, output logic [7:0] v);
        res_addr = 4'(a);
        @(negedge clk);
        v = res_data_w[s];
    endtask

    task automatic readback(input int s);
        logic [7:0] v;
        for (int a = 0; a < DEPTH; a++) begin
            if (res_ok[s][a]) begin
                rd(s, a, v);
                chk("res_readback", v, res_m[s][a]);
            end
        end
    endtask

    // One run: expected timeline follows from how many words are issued (n)
    // and the per-instruction period p = 1 + latency.
    task automatic run(input int s, input int len, input int abort_at, input bit disturb,
                       output int busy_seen);
        int p, n, lim, tot, comp;
        logic [19:0] exp_alu;
        p   = (s == 0) ? 2 : 4;
        lim = (len > DEPTH) ? DEPTH : len;
        n   = 0;
        while (n < lim && prog_m[s][n][19:16] != OP_HALT) n++;
        tot = n * p + 1;
        busy_seen = 0;
        $display("run dut=%0d len=%0d issued=%0d abort_at=%0d disturb=%0d", s, len, n, abort_at, disturb);
        prog_len = 5'(len);
        start[s] = 1'b1;
        for (int k = 1; k <= tot + 1; k++) begin
            @(negedge clk);
            start   = 2'b00;
            prog_we = 2'b00;
            if (k <= n * p)   exp_alu = prog_m[s][(k - 1) / p];
            else if (n > 0)   exp_alu = prog_m[s][n - 1];
            else              exp_alu = last_alu[s];
            comp = (k - 1) / p;
            if (comp > n) comp = n;
            if (busy_v[s]) busy_seen++;
            chk("busy", busy_v[s], k <= n * p);
            chk("done", done_v[s], k == tot);
            chk("res_count", res_count_w[s], comp);
            chk("alu_bus", alu_w[s], exp_alu);
            if (k >= 2 && k <= n * p + 1 && res_ok[s][(k - 2) / p])
                chk("read_old", res_data_w[s], res_m[s][(k - 2) / p]);
            if (k <= n * p) res_addr = 4'((k - 1) / p);
            if (k == abort_at) begin
                rst = 1'b1;
                @(negedge clk);
                rst = 1'b0;
                chk("abort_busy", busy_v[s], 0);
                chk("abort_done", done_v[s], 0);
                chk("abort_alu", alu_w[s], 0);
                chk("abort_res_count", res_count_w[s], 0);
                chk("abort_res_data", res_data_w[s], 0);
                for (int j = 0; j < comp; j++) begin
                    res_m[s][j]  = alu_f(prog_m[s][j][19:16], prog_m[s][j][15:8], prog_m[s][j][7:0]);
                    res_ok[s][j] = 1'b1;
                end
                last_alu[0] = '0;
                last_alu[1] = '0;
                return;
            end
            if (disturb && k == 2) begin
                start[s]   = 1'b1;
                prog_we[s] = 1'b1;
                prog_addr  = 4'd0;
                prog_data  = ~prog_m[s][0];
            end
        end
        for (int j = 0; j < n; j++) begin
            res_m[s][j]  = alu_f(prog_m[s][j][19:16], prog_m[s][j][15:8], prog_m[s][j][7:0]);
            res_ok[s][j] = 1'b1;
        end
        if (n > 0) last_alu[s] = prog_m[s][n - 1];
    endtask

    initial begin
        int bs;
        logic [7:0] v;
        logic [3:0] op;
        rst = 1'b1; prog_we = '0; start = '0; prog_addr = '0; prog_data = '0;
        prog_len = '0; res_addr = '0;
        last_alu[0] = '0; last_alu[1] = '0;
        repeat (3) @(negedge clk);
        for (int s = 0; s < 2; s++) begin
            chk("reset_busy", busy_v[s], 0);
            chk("reset_done", done_v[s], 0);
            chk("reset_res_count", res_count_w[s], 0);
            chk("reset_alu", alu_w[s], 0);
            chk("reset_res_data", res_data_w[s], 0);
        end
        rst = 1'b0;
        @(negedge clk);

        // Basic three-instruction program
        load(0, {OP_ADD, 8'h0A, 8'h05});
        load(1, {OP_SUB, 8'h00, 8'h01});
        load(2, {OP_AND, 8'hAA, 8'h0A});
        run(0, 3, 0, 1'b0, bs);
        chk("lit_busy_cycles", bs, 6);
        chk("lit_res_count", res_count_w[0], 3);
        rd(0, 0, v); chk("lit_add", v, 8'h0F);
        rd(0, 1, v); chk("lit_sub", v, 8'hFF);
        rd(0, 2, v); chk("lit_and", v, 8'h0A);

        // HALT in the middle stops the run before the OR
        load(0, {OP_XOR, 8'h08, 8'h0A});
        load(1, {OP_HALT, 8'h00, 8'h00});
        load(2, {OP_OR, 8'h08, 8'h02});
        run(0, 3, 0, 1'b0, bs);
        chk("lit_halt_res_count", res_count_w[0], 1);
        rd(0, 0, v); chk("lit_xor", v, 8'h02);

        // Empty program
        run(0, 0, 0, 1'b0, bs);
        chk("lit_empty_busy", bs, 0);

        // start and prog_we during a run are ignored; rerun proves prog[0] kept
        for (int i = 0; i < 4; i++)
            load(i, {4'($urandom_range(0, 14)), 8'($urandom), 8'($urandom)});
        run(0, 4, 0, 1'b1, bs);
        run(0, 4, 0, 1'b0, bs);

        // Reset on the second WAIT, then a clean run
        run(0, 4, 4, 1'b0, bs);
        readback(0);
        run(0, 4, 0, 1'b0, bs);

        // Leading HALT
        load(0, {OP_HALT, 8'h12, 8'h34});
        run(0, 5, 0, 1'b0, bs);
        chk("lit_lead_halt_count", res_count_w[0], 0);

        // Full-depth run at latency 3, then a clamped length on latency 1
        for (int i = 0; i < DEPTH; i++) load(i, {OP_ADD, 8'(i), 8'h01});
        run(1, DEPTH, 0, 1'b0, bs);
        chk("lit_lat3_busy_cycles", bs, 64);
        chk("lit_lat3_res_count", res_count_w[1], 16);
        for (int i = 0; i < DEPTH; i++) begin
            rd(1, i, v);
            chk("lit_lat3_res", v, 8'(i + 1));
        end
        run(0, 31, 0, 1'b0, bs);
        chk("lit_clamp_res_count", res_count_w[0], 16);

        // Randomized programs and lengths on both latencies
        for (int it = 0; it < 24; it++) begin
            int s;
            s = int'($urandom_range(0, 1));
            for (int w = 0; w < int'($urandom_range(0, 5)); w++) begin
                op = ($urandom_range(0, 7) == 0) ? OP_HALT : 4'($urandom_range(0, 14));
                load(int'($urandom_range(0, DEPTH - 1)), {op, 8'($urandom), 8'($urandom)});
            end
            run(s, int'($urandom_range(0, 31)), 0, 1'b0, bs);
            readback(s);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
